insn_fetch_unit: RTL and testbench

//  Front end that produces the 32-bit instruction word consumed by the decoder/control unit.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 55 +++++
 rtl/insn_fetch_unit.sv | 139 +++++++++++++
 tb/tb_insn_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int INSN_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  typedef enum logic {
    F_RUN,
    F_FLUSH
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'(PC_STEP - 1);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, insn} entries with a combinational head view.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clear,
  input  logic               i_push,
  input  fetch_entry_t       i_entry,
  input  logic               i_pop,
  output logic [CNT_W-1:0]   o_count,
  output fetch_entry_t       o_head
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/insn_fetch_unit.sv
// Instruction fetch front end: sequential imem requests, in-order response buffering,
// decode handshake, and redirect with flushing of every wrong-path response.
module insn_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INSN_W-1:0] dec_insn,
  output logic [31:0]       dec_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(DEPTH);

  fetch_state_t     r_state;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_rsp_pc;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;

  fetch_state_t     w_state_next;
  logic [CNT_W-1:0] w_out_next;
  logic [CNT_W-1:0] w_drop_next;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_entry;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp_push;
  logic             w_rsp_counted;
  logic             w_not_empty;
  logic             w_dec_valid;
  logic             w_room;

  // Space is reserved for every accepted request, so a returning word always fits.
  assign w_room        = ({1'b0, w_count} + {1'b0, r_outstanding}) < DEPTH_C;
  assign w_rsp_counted = imem_rsp_valid && (r_outstanding != '0);
  assign w_rsp_push    = rst_n && imem_rsp_valid && !redirect_valid && (r_drop_cnt == '0);
  assign w_not_empty   = rst_n && (w_count != '0);
  assign w_req_fire    = w_req_valid && imem_req_ready;

  always_comb begin
    w_state_next = r_state;
    w_req_valid  = 1'b0;
    w_dec_valid  = w_not_empty && !redirect_valid;
    case (r_state)
      F_RUN: begin
        w_req_valid = rst_n && !redirect_valid && (r_outstanding < MAX_OUT_C) && w_room;
        if (redirect_valid && (w_drop_next != '0)) w_state_next = F_FLUSH;
      end
      F_FLUSH: begin
        if (w_drop_next == '0) w_state_next = F_RUN;
      end
      default: w_state_next = F_RUN;
    endcase
  end

  always_comb begin
    w_out_next = r_outstanding;
    case ({w_req_fire, w_rsp_counted})
      2'b10:   w_out_next = r_outstanding + 1'b1;
      2'b01:   w_out_next = r_outstanding - 1'b1;
      default: w_out_next = r_outstanding;
    endcase
  end

  // On redirect every response still owed by memory belongs to the old path.
  always_comb begin
    w_drop_next = r_drop_cnt;
    if (redirect_valid) begin
      w_drop_next = w_rsp_counted ? (r_outstanding - 1'b1) : r_outstanding;
    end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
      w_drop_next = r_drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= F_RUN;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_outstanding <= w_out_next;
      r_drop_cnt    <= w_drop_next;
      if (redirect_valid) begin
        r_fetch_pc <= align_pc(redirect_pc);
        r_rsp_pc   <= align_pc(redirect_pc);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'(PC_STEP);
        if (w_rsp_push) r_rsp_pc   <= r_rsp_pc + 32'(PC_STEP);
      end
    end
  end

  assign w_push_entry = '{pc: r_rsp_pc, insn: imem_rsp_data};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (redirect_valid),
    .i_push  (w_rsp_push),
    .i_entry (w_push_entry),
    .i_pop   (w_dec_valid && dec_ready),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign dec_valid      = w_dec_valid;
  assign dec_insn       = w_not_empty ? w_head.insn : '0;
  assign dec_pc         = w_not_empty ? w_head.pc : '0;

`ifndef SYNTHESIS
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (r_outstanding != '0));
`endif

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Directed bench for insn_fetch_unit with a latency-programmable in-order imem model.
module tb_insn_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_insn;
  logic [31:0] dec_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  insn_fetch_unit #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_insn       (dec_insn),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_before;
    bit          dec_ready;
    bit          exp_req_valid;
    logic [31:0] exp_req_addr;
    bit          exp_dec_valid;
    logic [31:0] exp_dec_pc;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] dec_log[$];

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_dec_valid;
  logic [31:0] s_dec_pc;
  logic [31:0] s_dec_insn;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive imem response, sample outputs on negedge, update memory model.
  task automatic step();
    if (rst_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = insn_of(pend_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_dec_valid = dec_valid;
    s_dec_pc    = dec_pc;
    s_dec_insn  = dec_insn;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_rsp_valid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (s_req_valid && imem_req_ready) begin
        pend_addr.push_back(s_req_addr);
        pend_due.push_back(cyc + lat);
      end
      if (s_dec_valid && dec_ready) begin
        dec_log.push_back(s_dec_pc);
        $display("cycle %0d: decode pc=%h insn=%h", cyc, s_dec_pc, s_dec_insn);
        chk("dec_insn_on_fire", s_dec_insn, insn_of(s_dec_pc));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    dec_ready      = 1'b0;
    dec_log.delete();
    step();
    chk("rst_req_valid", 32'(s_req_valid), 32'd0);
    chk("rst_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("rst_dec_pc", s_dec_pc, 32'd0);
    step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_dec(input string name, input int n, input int budget);
    for (int b = 0; b < budget && dec_log.size() < n; b++) step();
    chk(name, 32'(dec_log.size() >= n), 32'd1);
  endtask

  vec_t vecs[24];

  initial begin
    // Test 1 (vectors 0..7): streaming with 1-cycle memory and decode always ready.
    for (int k = 0; k < 8; k++) begin
      vecs[k].rst_before    = (k == 0);
      vecs[k].dec_ready     = 1'b1;
      vecs[k].exp_req_valid = 1'b1;
      vecs[k].exp_req_addr  = 32'(4 * k);
      vecs[k].exp_dec_valid = (k >= 2);
      vecs[k].exp_dec_pc    = (k >= 2) ? 32'(4 * (k - 2)) : 32'd0;
    end
    // Test 2 (vectors 8..23): decode stalled for 10 cycles, then released.
    for (int k = 0; k < 16; k++) begin
      vecs[8 + k].rst_before    = (k == 0);
      vecs[8 + k].dec_ready     = (k >= 10);
      vecs[8 + k].exp_req_valid = (k < 4) || (k >= 11);
      vecs[8 + k].exp_req_addr  = (k < 4) ? 32'(4 * k) : 32'(16 + 4 * (k - 11));
      vecs[8 + k].exp_dec_valid = (k >= 2);
      vecs[8 + k].exp_dec_pc    = (k < 11) ? 32'd0 : 32'(4 * (k - 10));
    end

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].rst_before) begin
        lat = 1;
        do_reset();
      end
      dec_ready = vecs[i].dec_ready;
      step();
      chk($sformatf("v%0d_req_valid", i), 32'(s_req_valid), 32'(vecs[i].exp_req_valid));
      if (vecs[i].exp_req_valid)
        chk($sformatf("v%0d_req_addr", i), s_req_addr, vecs[i].exp_req_addr);
      chk($sformatf("v%0d_dec_valid", i), 32'(s_dec_valid), 32'(vecs[i].exp_dec_valid));
      chk($sformatf("v%0d_dec_pc", i), s_dec_pc, vecs[i].exp_dec_pc);
      chk($sformatf("v%0d_dec_insn", i), s_dec_insn,
          vecs[i].exp_dec_valid ? insn_of(vecs[i].exp_dec_pc) : 32'd0);
    end

    // Test 3: two requests in flight (latency 3), redirect to 0x100.
    do_reset();
    lat = 3;
    dec_ready = 1'b1;
    step();
    chk("t3_req0_addr", s_req_addr, 32'h0);
    step();
    chk("t3_req1_valid", 32'(s_req_valid), 32'd1);
    chk("t3_req1_addr", s_req_addr, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    chk("t3_redir_req_valid", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t3_flush_req_valid_a", 32'(s_req_valid), 32'd0);
    step();
    chk("t3_flush_req_valid_b", 32'(s_req_valid), 32'd0);
    step();
    chk("t3_new_req_valid", 32'(s_req_valid), 32'd1);
    chk("t3_new_req_addr", s_req_addr, 32'h100);
    wait_dec("t3_dec_timeout", 2, 30);
    if (dec_log.size() >= 2) begin
      chk("t3_first_dec_pc", dec_log[0], 32'h100);
      chk("t3_second_dec_pc", dec_log[1], 32'h104);
    end

    // Test 4: redirect coincides with a response while one more is outstanding.
    do_reset();
    lat = 2;
    repeat (4) step();
    step();
    chk("t4_pre_dec_valid", 32'(s_dec_valid), 32'd1);
    chk("t4_pre_dec_pc", s_dec_pc, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    dec_ready      = 1'b1;
    step();
    chk("t4_redir_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("t4_redir_req_valid", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t4_flush_req_valid", 32'(s_req_valid), 32'd0);
    chk("t4_flush_dec_valid", 32'(s_dec_valid), 32'd0);
    step();
    chk("t4_new_req_valid", 32'(s_req_valid), 32'd1);
    chk("t4_new_req_addr", s_req_addr, 32'h200);
    wait_dec("t4_dec_timeout", 1, 30);
    if (dec_log.size() >= 1) chk("t4_first_dec_pc", dec_log[0], 32'h200);

    // Test 5: unaligned redirect near the top of the address space wraps to 0.
    do_reset();
    lat = 1;
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    chk("t5_redir_req_valid", 32'(s_req_valid), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t5_req_a_valid", 32'(s_req_valid), 32'd1);
    chk("t5_req_a_addr", s_req_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_req_b_valid", 32'(s_req_valid), 32'd1);
    chk("t5_req_b_addr", s_req_addr, 32'h0);
    wait_dec("t5_dec_timeout", 2, 20);
    if (dec_log.size() >= 2) begin
      chk("t5_dec_pc_a", dec_log[0], 32'hFFFF_FFFC);
      chk("t5_dec_pc_b", dec_log[1], 32'h0);
    end

    // Test 6: reset while the queue holds words and requests are in flight.
    do_reset();
    lat = 4;
    repeat (8) step();
    do_reset();
    step();
    chk("t6_req_valid", 32'(s_req_valid), 32'd1);
    chk("t6_req_addr", s_req_addr, 32'h0);
    chk("t6_dec_valid", 32'(s_dec_valid), 32'd0);
    chk("t6_dec_pc", s_dec_pc, 32'd0);
    chk("t6_dec_insn", s_dec_insn, 32'd0);
    dec_ready = 1'b1;
    wait_dec("t6_dec_timeout", 1, 20);
    if (dec_log.size() >= 1) chk("t6_first_dec_pc", dec_log[0], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
